mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS-subset processor. It sequences a shared datapath: one ALU, one memory port and one register file. Each instruction runs through FETCH/DECODE/EXEC/MEM/WB states, and the unit drives the same select codes the datapath muxes already decode. It also stalls on a memory-ready handshake and counts retired instructions.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  6  opcode from IR; valid from DECODE onward
- funct  in  6  function field from IR
- zero  in  1  ALU equality flag (beq compare)
- mem_rdy  in  1  memory port completes the current access this cycle
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- ALUctr  out  3  001 add, 010 sub, 011 or, 000 pass/default
- DMWrite  out  1  data-memory write request
- npc_sel  out  2  00 PC+4, 01 jump, 11 branch target
- RegWrt  out  1  register-file write enable
- ExtOp  out  2  00 lui (imm<<16), 10 sign-extend
- RegDstSel  out  2  00 rt, 01 rd
- MemToRegSel  out  2  00 ALU, 01 memory, 11 lui immediate
- AluSrcSel  out  1  0 register B, 1 extended immediate
- state  out  3  current state, for debug
- instr_done  out  1  one-cycle pulse on the retiring cycle
- illegal  out  1  one-cycle pulse on an unsupported op/funct in DECODE
- instr_cnt  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

## Operation
- Supported instructions: add, sub, or (R-type); addiu, lw, sw, beq, lui, j.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 go to FETCH on the next edge with all enables 0.
- FETCH
  - IRWr=PCWr=1 and npc_sel=00 only while mem_rdy=1; then go to DECODE.
  - With mem_rdy=0, hold in FETCH with all enables 0.
- DECODE
  - j: PCWr=1, npc_sel=01, instr_done=1, go to FETCH.
  - Illegal op/funct: illegal=1, no enables, go to FETCH. Not counted.
  - All others: go to EXEC.
- EXEC
  - add/sub/or: ALUctr 001/010/011, AluSrcSel=0, go to WB.
  - addiu: ALUctr=001, AluSrcSel=1, ExtOp=10, go to WB.
  - lw/sw: same ALU setup as addiu (address calculation), go to MEM.
  - lui: ExtOp=00, go to WB.
  - beq: ALUctr=010, AluSrcSel=0.
    - If zero=1: PCWr=1, npc_sel=11.
    - Either way: instr_done=1, go to FETCH.
- MEM
  - sw: DMWrite=1 held until mem_rdy=1. On mem_rdy: instr_done=1, go to FETCH.
  - lw: hold until mem_rdy=1, then go to WB.
- WB
  - RegWrt=1, instr_done=1, go to FETCH.
  - RegDstSel=01 for R-type, 00 for addiu/lw/lui.
  - MemToRegSel: 00 for R-type/addiu, 01 for lw, 11 for lui.
- Select outputs not listed for a state default to 0.
- instr_cnt increments by 1 on every cycle where instr_done=1.

## Timing
- Outputs are combinational from the state register, op, funct, zero and mem_rdy. state and instr_cnt are registered.
- Latency in cycles with mem_rdy tied high:
  - j: 2
  - beq: 3
  - sw: 4
  - add/sub/or/addiu/lui: 4
  - lw: 5
- Each cycle mem_rdy=0 in FETCH or MEM adds one cycle.
- mem_rdy is sampled only in FETCH and MEM and ignored elsewhere.
- While rst=0: state=FETCH, instr_cnt=0, and every output is 0, including IRWr/PCWr regardless of mem_rdy.
- Reset asserted mid-instruction aborts it immediately: no partial RegWrt/DMWrite, no count.
- instr_cnt wrap: all-ones + 1 → 0, no flag.

## Structure
- Shared package mc_ctrl_pkg holds:
  - opcode/funct constants
  - state encoding
  - ALUctr, npc_sel, ExtOp, RegDstSel and MemToRegSel codes
- The datapath muxes use the same package.
- Sub-module mc_decode: combinational op/funct → one-hot instruction class (rtype_add, rtype_sub, rtype_or, addiu, lw, sw, beq, lui, j, illegal).
- mc_ctrl keeps the FSM, output decode and counter.

## Test plan
- add (op=000000, funct=100000), mem_rdy=1 → IRWr/PCWr in cycle 0; WB in cycle 3 with RegWrt=1, RegDstSel=01, MemToRegSel=00; instr_done once; instr_cnt=1.
- lw with mem_rdy low for 3 cycles in MEM → 8 cycles total; RegWrt only in the final cycle; MemToRegSel=01.
- sw with mem_rdy=1 → DMWrite=1 for exactly 1 cycle in MEM; RegWrt never asserted.
- beq with zero=1 then zero=0 → first run: PCWr=1, npc_sel=11 in EXEC; second run: PCWr=0; both retire in 3 cycles.
- j then op=111111 → j: PCWr with npc_sel=01 in DECODE. Illegal op: illegal pulse, instr_cnt unchanged, returns to FETCH.
- rst dropped during WB of addiu → RegWrt falls immediately; state=0 and instr_cnt=0. After release with CNT_W=4 and 16 retirements → instr_cnt wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit and the datapath muxes it steers.
package mc_ctrl_pkg;

    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned STATE_W  = 3;
    localparam int unsigned ALUCTR_W = 3;
    localparam int unsigned NPC_W    = 2;
    localparam int unsigned EXT_W    = 2;
    localparam int unsigned RDST_W   = 2;
    localparam int unsigned M2R_W    = 2;

    // Opcodes
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    // R-type function codes
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;

    // Controller states; codes 5-7 are unused and recover to FETCH
    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    // ALU operation select
    localparam logic [ALUCTR_W-1:0] ALU_PASS = 3'b000;
    localparam logic [ALUCTR_W-1:0] ALU_ADD  = 3'b001;
    localparam logic [ALUCTR_W-1:0] ALU_SUB  = 3'b010;
    localparam logic [ALUCTR_W-1:0] ALU_OR   = 3'b011;

    // Next-PC select
    localparam logic [NPC_W-1:0] NPC_PC4    = 2'b00;
    localparam logic [NPC_W-1:0] NPC_JUMP   = 2'b01;
    localparam logic [NPC_W-1:0] NPC_BRANCH = 2'b11;

    // Immediate extender mode
    localparam logic [EXT_W-1:0] EXT_LUI  = 2'b00;
    localparam logic [EXT_W-1:0] EXT_SIGN = 2'b10;

    // Register-file destination select
    localparam logic [RDST_W-1:0] RDST_RT = 2'b00;
    localparam logic [RDST_W-1:0] RDST_RD = 2'b01;

    // Write-back data select
    localparam logic [M2R_W-1:0] M2R_ALU = 2'b00;
    localparam logic [M2R_W-1:0] M2R_MEM = 2'b01;
    localparam logic [M2R_W-1:0] M2R_LUI = 2'b11;

    // One-hot instruction class produced by the decoder
    typedef struct packed {
        logic rtype_add;
        logic rtype_sub;
        logic rtype_or;
        logic addiu;
        logic lw;
        logic sw;
        logic beq;
        logic lui;
        logic j;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational op/funct decoder producing a one-hot instruction class.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    output instr_class_t       cls
);

    // Map opcode (and funct for R-type) onto exactly one class bit
    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: cls.rtype_add = 1'b1;
                    FUNCT_SUB: cls.rtype_sub = 1'b1;
                    FUNCT_OR:  cls.rtype_or  = 1'b1;
                    default:   cls.illegal   = 1'b1;
                endcase
            end
            OP_ADDIU: cls.addiu   = 1'b1;
            OP_LW:    cls.lw      = 1'b1;
            OP_SW:    cls.sw      = 1'b1;
            OP_BEQ:   cls.beq     = 1'b1;
            OP_LUI:   cls.lui     = 1'b1;
            OP_J:     cls.j       = 1'b1;
            default:  cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing, datapath selects
// and a retired-instruction counter. Selects are combinational from state and
// the IR fields, and are forced low while reset is held.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OP_W-1:0]     op,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                zero,
    input  logic                mem_rdy,
    output logic                PCWr,
    output logic                IRWr,
    output logic [ALUCTR_W-1:0] ALUctr,
    output logic                DMWrite,
    output logic [NPC_W-1:0]    npc_sel,
    output logic                RegWrt,
    output logic [EXT_W-1:0]    ExtOp,
    output logic [RDST_W-1:0]   RegDstSel,
    output logic [M2R_W-1:0]    MemToRegSel,
    output logic                AluSrcSel,
    output logic [STATE_W-1:0]  state,
    output logic                instr_done,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_cnt
);

    state_t       state_q;
    state_t       state_d;
    instr_class_t cls;
    logic         is_rtype;

    mc_decode u_decode (
        .op    (op),
        .funct (funct),
        .cls   (cls)
    );

    assign is_rtype = cls.rtype_add | cls.rtype_sub | cls.rtype_or;
    assign state    = state_q;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; mem_rdy only matters in FETCH and MEM
    always_comb begin
        state_d = ST_FETCH;
        case (state_q)
            ST_FETCH:  state_d = mem_rdy ? ST_DECODE : ST_FETCH;
            ST_DECODE: state_d = (cls.j || cls.illegal) ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
                if (cls.lw || cls.sw) begin
                    state_d = ST_MEM;
                end else if (cls.beq) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (!mem_rdy) begin
                    state_d = ST_MEM;
                end else if (cls.lw) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_FETCH;
        endcase
    end

    // Output decode; everything defaults low and stays low during reset
    always_comb begin
        PCWr        = 1'b0;
        IRWr        = 1'b0;
        ALUctr      = ALU_PASS;
        DMWrite     = 1'b0;
        npc_sel     = NPC_PC4;
        RegWrt      = 1'b0;
        ExtOp       = EXT_LUI;
        RegDstSel   = RDST_RT;
        MemToRegSel = M2R_ALU;
        AluSrcSel   = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        if (rst) begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_rdy) begin
                        IRWr    = 1'b1;
                        PCWr    = 1'b1;
                        npc_sel = NPC_PC4;
                    end
                end
                ST_DECODE: begin
                    if (cls.j) begin
                        PCWr       = 1'b1;
                        npc_sel    = NPC_JUMP;
                        instr_done = 1'b1;
                    end else if (cls.illegal) begin
                        illegal = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (cls.rtype_add) begin
                        ALUctr = ALU_ADD;
                    end else if (cls.rtype_sub) begin
                        ALUctr = ALU_SUB;
                    end else if (cls.rtype_or) begin
                        ALUctr = ALU_OR;
                    end else if (cls.addiu || cls.lw || cls.sw) begin
                        ALUctr    = ALU_ADD;
                        AluSrcSel = 1'b1;
                        ExtOp     = EXT_SIGN;
                    end else if (cls.lui) begin
                        ExtOp = EXT_LUI;
                    end else if (cls.beq) begin
                        ALUctr     = ALU_SUB;
                        instr_done = 1'b1;
                        if (zero) begin
                            PCWr    = 1'b1;
                            npc_sel = NPC_BRANCH;
                        end
                    end
                end
                ST_MEM: begin
                    if (cls.sw) begin
                        DMWrite    = 1'b1;
                        instr_done = mem_rdy;
                    end
                end
                ST_WB: begin
                    RegWrt     = 1'b1;
                    instr_done = 1'b1;
                    RegDstSel  = is_rtype ? RDST_RD : RDST_RT;
                    if (cls.lw) begin
                        MemToRegSel = M2R_MEM;
                    end else if (cls.lui) begin
                        MemToRegSel = M2R_LUI;
                    end else begin
                        MemToRegSel = M2R_ALU;
                    end
                end
                default: ;
            endcase
        end
    end

    // Retired-instruction counter, wraps silently
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_cnt <= '0;
        end else if (instr_done) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected selects for each instruction class,
// memory stalls, reset abort and counter wrap (counter built 4 bits wide).
module tb_mc_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_rdy;
    logic        PCWr;
    logic        IRWr;
    logic [2:0]  ALUctr;
    logic        DMWrite;
    logic [1:0]  npc_sel;
    logic        RegWrt;
    logic [1:0]  ExtOp;
    logic [1:0]  RegDstSel;
    logic [1:0]  MemToRegSel;
    logic        AluSrcSel;
    logic [2:0]  state;
    logic        instr_done;
    logic        illegal;
    logic [3:0]  instr_cnt;

    logic [17:0] ctl_obs;
    int          vec_cnt;
    int          err_cnt;
    logic [3:0]  exp_cnt;

    logic [17:0] c_zero, c_fetch, c_ex_add, c_ex_sub, c_ex_or, c_ex_imm;
    logic [17:0] c_ex_beqt, c_ex_beqn, c_wb_r, c_wb_i, c_wb_lw, c_wb_lui;
    logic [17:0] c_mem_sw, c_mem_sw_wait, c_dec_j, c_dec_ill;

    mc_ctrl #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_rdy     (mem_rdy),
        .PCWr        (PCWr),
        .IRWr        (IRWr),
        .ALUctr      (ALUctr),
        .DMWrite     (DMWrite),
        .npc_sel     (npc_sel),
        .RegWrt      (RegWrt),
        .ExtOp       (ExtOp),
        .RegDstSel   (RegDstSel),
        .MemToRegSel (MemToRegSel),
        .AluSrcSel   (AluSrcSel),
        .state       (state),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .instr_cnt   (instr_cnt)
    );

    assign ctl_obs = {PCWr, IRWr, ALUctr, DMWrite, npc_sel, RegWrt, ExtOp,
                      RegDstSel, MemToRegSel, AluSrcSel, instr_done, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Pack expected control fields in the same order as ctl_obs
    function automatic logic [17:0] ctl(input logic pcwr, input logic irwr, input logic [2:0] alu,
                                        input logic dmw, input logic [1:0] npc, input logic regw,
                                        input logic [1:0] ext, input logic [1:0] rdst,
                                        input logic [1:0] m2r, input logic asrc,
                                        input logic done, input logic ill);
        return {pcwr, irwr, alu, dmw, npc, regw, ext, rdst, m2r, asrc, done, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check mid-cycle, advance to next falling edge
    task automatic run_cycle(input string tag, input logic rdy, input logic z,
                             input logic [2:0] exp_state, input logic [17:0] exp_ctl);
        mem_rdy = rdy;
        zero    = z;
        #1;
        chk({tag, "/state"}, 32'(state), 32'(exp_state));
        chk({tag, "/ctl"}, 32'(ctl_obs), 32'(exp_ctl));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f);
        op    = o;
        funct = f;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "/cnt"}, 32'(instr_cnt), 32'(exp_cnt));
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        exp_cnt = 4'd0;

        c_zero        = '0;
        c_fetch       = ctl(1, 1, 3'd0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        c_ex_add      = ctl(0, 0, 3'd1, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        c_ex_sub      = ctl(0, 0, 3'd2, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        c_ex_or       = ctl(0, 0, 3'd3, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        c_ex_imm      = ctl(0, 0, 3'd1, 0, 2'b00, 0, 2'b10, 2'b00, 2'b00, 1, 0, 0);
        c_ex_beqt     = ctl(1, 0, 3'd2, 0, 2'b11, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        c_ex_beqn     = ctl(0, 0, 3'd2, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        c_wb_r        = ctl(0, 0, 3'd0, 0, 2'b00, 1, 2'b00, 2'b01, 2'b00, 0, 1, 0);
        c_wb_i        = ctl(0, 0, 3'd0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        c_wb_lw       = ctl(0, 0, 3'd0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b01, 0, 1, 0);
        c_wb_lui      = ctl(0, 0, 3'd0, 0, 2'b00, 1, 2'b00, 2'b00, 2'b11, 0, 1, 0);
        c_mem_sw      = ctl(0, 0, 3'd0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        c_mem_sw_wait = ctl(0, 0, 3'd0, 1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0);
        c_dec_j       = ctl(1, 0, 3'd0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        c_dec_ill     = ctl(0, 0, 3'd0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 1);

        // Reset held with mem_rdy high: nothing may assert
        rst     = 1'b0;
        mem_rdy = 1'b1;
        zero    = 1'b0;
        set_instr(6'b000000, 6'b100000);
        #2;
        chk("reset/state", 32'(state), 32'd0);
        chk("reset/ctl", 32'(ctl_obs), 32'd0);
        chk_cnt("reset");
        @(negedge clk);
        rst = 1'b1;

        // add
        set_instr(6'b000000, 6'b100000);
        run_cycle("add/F", 1, 0, 3'd0, c_fetch);
        run_cycle("add/D", 1, 0, 3'd1, c_zero);
        run_cycle("add/E", 1, 0, 3'd2, c_ex_add);
        run_cycle("add/W", 1, 0, 3'd4, c_wb_r);
        exp_cnt = 4'd1;
        chk_cnt("add");

        // sub with one fetch stall
        set_instr(6'b000000, 6'b100010);
        run_cycle("sub/Fwait", 0, 0, 3'd0, c_zero);
        run_cycle("sub/F", 1, 0, 3'd0, c_fetch);
        run_cycle("sub/D", 1, 0, 3'd1, c_zero);
        run_cycle("sub/E", 1, 0, 3'd2, c_ex_sub);
        run_cycle("sub/W", 1, 0, 3'd4, c_wb_r);
        exp_cnt = 4'd2;
        chk_cnt("sub");

        // or with mem_rdy low outside FETCH/MEM: must not stall
        set_instr(6'b000000, 6'b100101);
        run_cycle("or/F", 1, 0, 3'd0, c_fetch);
        run_cycle("or/D", 0, 1, 3'd1, c_zero);
        run_cycle("or/E", 0, 1, 3'd2, c_ex_or);
        run_cycle("or/W", 0, 1, 3'd4, c_wb_r);
        exp_cnt = 4'd3;
        chk_cnt("or");

        // addiu
        set_instr(6'b001001, 6'b010101);
        run_cycle("addiu/F", 1, 0, 3'd0, c_fetch);
        run_cycle("addiu/D", 1, 0, 3'd1, c_zero);
        run_cycle("addiu/E", 1, 0, 3'd2, c_ex_imm);
        run_cycle("addiu/W", 1, 0, 3'd4, c_wb_i);
        exp_cnt = 4'd4;
        chk_cnt("addiu");

        // lw with three memory wait cycles: 8 cycles total
        set_instr(6'b100011, 6'b000000);
        run_cycle("lw/F", 1, 0, 3'd0, c_fetch);
        run_cycle("lw/D", 1, 0, 3'd1, c_zero);
        run_cycle("lw/E", 1, 0, 3'd2, c_ex_imm);
        run_cycle("lw/M0", 0, 0, 3'd3, c_zero);
        run_cycle("lw/M1", 0, 0, 3'd3, c_zero);
        run_cycle("lw/M2", 0, 0, 3'd3, c_zero);
        run_cycle("lw/M3", 1, 0, 3'd3, c_zero);
        run_cycle("lw/W", 1, 0, 3'd4, c_wb_lw);
        exp_cnt = 4'd5;
        chk_cnt("lw");

        // sw, no wait
        set_instr(6'b101011, 6'b000000);
        run_cycle("sw/F", 1, 0, 3'd0, c_fetch);
        run_cycle("sw/D", 1, 0, 3'd1, c_zero);
        run_cycle("sw/E", 1, 0, 3'd2, c_ex_imm);
        run_cycle("sw/M", 1, 0, 3'd3, c_mem_sw);
        exp_cnt = 4'd6;
        chk_cnt("sw");

        // sw with one wait: DMWrite held, done only on ready
        run_cycle("sw2/F", 1, 0, 3'd0, c_fetch);
        run_cycle("sw2/D", 1, 0, 3'd1, c_zero);
        run_cycle("sw2/E", 1, 0, 3'd2, c_ex_imm);
        run_cycle("sw2/Mwait", 0, 0, 3'd3, c_mem_sw_wait);
        run_cycle("sw2/M", 1, 0, 3'd3, c_mem_sw);
        exp_cnt = 4'd7;
        chk_cnt("sw2");

        // lui
        set_instr(6'b001111, 6'b000000);
        run_cycle("lui/F", 1, 0, 3'd0, c_fetch);
        run_cycle("lui/D", 1, 0, 3'd1, c_zero);
        run_cycle("lui/E", 1, 0, 3'd2, c_zero);
        run_cycle("lui/W", 1, 0, 3'd4, c_wb_lui);
        exp_cnt = 4'd8;
        chk_cnt("lui");

        // beq taken, then not taken
        set_instr(6'b000100, 6'b000000);
        run_cycle("beqt/F", 1, 0, 3'd0, c_fetch);
        run_cycle("beqt/D", 1, 0, 3'd1, c_zero);
        run_cycle("beqt/E", 1, 1, 3'd2, c_ex_beqt);
        exp_cnt = 4'd9;
        chk_cnt("beqt");
        run_cycle("beqn/F", 1, 1, 3'd0, c_fetch);
        run_cycle("beqn/D", 1, 1, 3'd1, c_zero);
        run_cycle("beqn/E", 1, 0, 3'd2, c_ex_beqn);
        exp_cnt = 4'd10;
        chk_cnt("beqn");

        // j
        set_instr(6'b000010, 6'b000000);
        run_cycle("j/F", 1, 0, 3'd0, c_fetch);
        run_cycle("j/D", 1, 0, 3'd1, c_dec_j);
        exp_cnt = 4'd11;
        chk_cnt("j");

        // illegal opcode, then illegal R-type funct: pulse, no count, back to FETCH
        set_instr(6'b111111, 6'b000000);
        run_cycle("ill_op/F", 1, 0, 3'd0, c_fetch);
        run_cycle("ill_op/D", 1, 0, 3'd1, c_dec_ill);
        chk_cnt("ill_op");
        set_instr(6'b000000, 6'b000000);
        run_cycle("ill_fn/F", 1, 0, 3'd0, c_fetch);
        run_cycle("ill_fn/D", 1, 0, 3'd1, c_dec_ill);
        chk_cnt("ill_fn");

        // Reset dropped during addiu write-back aborts the retire
        set_instr(6'b001001, 6'b000000);
        run_cycle("rst/F", 1, 0, 3'd0, c_fetch);
        run_cycle("rst/D", 1, 0, 3'd1, c_zero);
        run_cycle("rst/E", 1, 0, 3'd2, c_ex_imm);
        mem_rdy = 1'b1;
        #1;
        chk("rst/W_ctl", 32'(ctl_obs), 32'(c_wb_i));
        rst = 1'b0;
        #1;
        chk("rst/abort_ctl", 32'(ctl_obs), 32'd0);
        chk("rst/abort_state", 32'(state), 32'd0);
        exp_cnt = 4'd0;
        chk_cnt("rst/abort");
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst/held_ctl", 32'(ctl_obs), 32'd0);
        chk("rst/held_state", 32'(state), 32'd0);
        chk_cnt("rst/held");
        rst = 1'b1;

        // 16 retirements wrap the 4-bit counter back to zero
        set_instr(6'b000010, 6'b000000);
        for (int i = 0; i < 16; i++) begin
            run_cycle("wrap/F", 1, 0, 3'd0, c_fetch);
            run_cycle("wrap/D", 1, 0, 3'd1, c_dec_j);
            exp_cnt = exp_cnt + 4'd1;
            if (i == 14 || i == 15) begin
                chk_cnt("wrap");
            end
        end
        chk("wrap/final", 32'(instr_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
